// File: rtl/stove_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stove_pkg
// Description : Constants and types shared by the stove power-control blocks.
//               MAX_LEVEL        highest user power level (level units)
//               SLOTS_PER_PERIOD time slots in one power-distribution period
//               ONE_SECOND       clk cycles per second at the 50 MHz system clock
//               level_t          4-bit power level
//               pref_t           which surface wins a clipped budget
//               clamp_level      saturate a raw 4-bit request to MAX_LEVEL
// Revision    : 1.0  initial release
// ============================================================================
package stove_pkg;

  typedef logic [3:0] level_t;

  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } pref_t;

  localparam level_t      MAX_LEVEL        = 4'd9;
  localparam logic [3:0]  SLOTS_PER_PERIOD = 4'd10;
  localparam int          ONE_SECOND       = 50_000_000;

  // Raw request values 10..15 saturate to the maximum level.
  function automatic level_t clamp_level(input logic [3:0] raw);
    return (raw > MAX_LEVEL) ? MAX_LEVEL : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : slot_timer
// Description : Prescaler and slot counter that carve time into periods of
//               SLOTS_PER_PERIOD slots, each SLOT_CYCLES clk cycles long.
//               Both counters are held at zero while enable is low, so the
//               first enabled cycle is always the first cycle of a period.
// Ports       : clk          system clock (rising edge)
//               async_reset  asynchronous reset, active low
//               enable       run the counters; low clears them
//               slot         current slot index 0..SLOTS_PER_PERIOD-1
//               slot_tick    last cycle of the current slot
//               period_start first cycle of a period (slot 0, prescaler 0)
// Revision    : 1.0  initial release
// ============================================================================
module slot_timer
  import stove_pkg::*;
#(
  parameter int SLOT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic       enable,
  output logic [3:0] slot,
  output logic       slot_tick,
  output logic       period_start
);

  localparam int                 c_PRE_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(SLOT_CYCLES - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_ONE   = c_PRE_W'(1);
  localparam logic [3:0]         c_SLOT_LAST = SLOTS_PER_PERIOD - 4'd1;

  logic [c_PRE_W-1:0] r_prescale;
  logic [3:0]         r_slot;
  logic               w_tick;

  assign w_tick       = enable && (r_prescale == c_PRE_LAST);
  assign slot         = r_slot;
  assign slot_tick    = w_tick;
  assign period_start = enable && (r_prescale == '0) && (r_slot == 4'd0);

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_prescale <= '0;
      r_slot     <= 4'd0;
    end else if (!enable) begin
      r_prescale <= '0;
      r_slot     <= 4'd0;
    end else if (w_tick) begin
      r_prescale <= '0;
      r_slot     <= (r_slot == c_SLOT_LAST) ? 4'd0 : r_slot + 4'd1;
    end else begin
      r_prescale <= r_prescale + c_PRE_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/heater_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : heater_scheduler
// Description : Time-slot power scheduler for a two-surface stove. Each
//               period the requested levels are sampled and, if their sum
//               exceeds MAX_SUM, the preferred surface keeps its level and
//               the other gets the remainder. The preference alternates
//               after every clipped period so both surfaces share the
//               shortfall. Heater A is driven from the start of the period,
//               heater B is packed against the end to minimise overlap.
// Ports       : clk            system clock (rising edge)
//               async_reset    asynchronous reset, active low
//               enable         stove on and not locked
//               level_a/b      requested levels 0..9 (10..15 clamp to 9)
//               heat_a/b       heater drives (registered)
//               budget_limited current period's grants were clipped
//               period_start   one-cycle pulse in the first period cycle
// Config      : HEATER_SCHED_SOFTSTART_EN  when defined, each grant can rise
//               by at most one level per period; decreases are immediate.
// Revision    : 1.0  initial release
// ============================================================================
module heater_scheduler
  import stove_pkg::*;
#(
  parameter int SLOT_CYCLES = 5_000_000,
  parameter int MAX_SUM     = 12
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic       enable,
  input  logic [3:0] level_a,
  input  logic [3:0] level_b,
  output logic       heat_a,
  output logic       heat_b,
  output logic       budget_limited,
  output logic       period_start
);

  localparam logic [4:0] c_MAX_SUM   = 5'(MAX_SUM);
  localparam logic [3:0] c_SLOT_LAST = SLOTS_PER_PERIOD - 4'd1;

  // Slot timing
  logic [3:0] w_slot;
  logic       w_slot_tick;
  logic       w_period_start;
  logic       w_period_end;

  slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_slot_timer (
    .clk          (clk),
    .async_reset  (async_reset),
    .enable       (enable),
    .slot         (w_slot),
    .slot_tick    (w_slot_tick),
    .period_start (w_period_start)
  );

  assign w_period_end = w_slot_tick && (w_slot == c_SLOT_LAST);

  // Per-period state
  level_t r_grant_a;
  level_t r_grant_b;
  logic   r_limited;
  pref_t  r_pref;

  // Registered outputs
  logic r_heat_a;
  logic r_heat_b;
  logic r_budget_limited;
  logic r_period_start;

  // Budget split of the sampled requests
  level_t     w_la;
  level_t     w_lb;
  logic [4:0] w_sum;
  level_t     w_tgt_a;
  level_t     w_tgt_b;
  logic       w_clip;

  assign w_la  = clamp_level(level_a);
  assign w_lb  = clamp_level(level_b);
  assign w_sum = {1'b0, w_la} + {1'b0, w_lb};

  // When clipped, the loser's share is MAX_SUM minus the winner's level;
  // MAX_SUM >= 9 keeps this non-negative and below the loser's request.
  always_comb begin
    w_tgt_a = w_la;
    w_tgt_b = w_lb;
    w_clip  = 1'b0;
    if (w_sum > c_MAX_SUM) begin
      w_clip = 1'b1;
      if (r_pref == PREF_A) begin
        w_tgt_b = level_t'(c_MAX_SUM - {1'b0, w_la});
      end else begin
        w_tgt_a = level_t'(c_MAX_SUM - {1'b0, w_lb});
      end
    end
  end

  // Grants applied to the new period
  level_t w_new_a;
  level_t w_new_b;

`ifdef HEATER_SCHED_SOFTSTART_EN
  // The held grants are the previous period's values and are cleared while
  // disabled, so a restart ramps up again from zero.
  always_comb begin
    w_new_a = w_tgt_a;
    w_new_b = w_tgt_b;
    if (w_tgt_a > r_grant_a) begin
      w_new_a = r_grant_a + 4'd1;
    end
    if (w_tgt_b > r_grant_b) begin
      w_new_b = r_grant_b + 4'd1;
    end
  end
`else
  assign w_new_a = w_tgt_a;
  assign w_new_b = w_tgt_b;
`endif

  // In the sampling cycle the registers still hold the old period, so the
  // output decode uses the freshly computed values instead.
  level_t w_cur_ga;
  level_t w_cur_gb;
  logic   w_cur_lim;

  assign w_cur_ga  = w_period_start ? w_new_a : r_grant_a;
  assign w_cur_gb  = w_period_start ? w_new_b : r_grant_b;
  assign w_cur_lim = w_period_start ? w_clip  : r_limited;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_grant_a        <= 4'd0;
      r_grant_b        <= 4'd0;
      r_limited        <= 1'b0;
      r_pref           <= PREF_A;
      r_heat_a         <= 1'b0;
      r_heat_b         <= 1'b0;
      r_budget_limited <= 1'b0;
      r_period_start   <= 1'b0;
    end else if (!enable) begin
      // Preference is deliberately kept across disabled intervals.
      r_grant_a        <= 4'd0;
      r_grant_b        <= 4'd0;
      r_limited        <= 1'b0;
      r_heat_a         <= 1'b0;
      r_heat_b         <= 1'b0;
      r_budget_limited <= 1'b0;
      r_period_start   <= 1'b0;
    end else begin
      if (w_period_start) begin
        r_grant_a <= w_new_a;
        r_grant_b <= w_new_b;
        r_limited <= w_clip;
      end
      // Only a period that runs to completion hands the preference over.
      if (w_period_end && r_limited) begin
        r_pref <= (r_pref == PREF_A) ? PREF_B : PREF_A;
      end
      r_heat_a         <= (w_slot < w_cur_ga);
      r_heat_b         <= (w_slot >= (SLOTS_PER_PERIOD - w_cur_gb));
      r_budget_limited <= w_cur_lim;
      r_period_start   <= w_period_start;
    end
  end

  assign heat_a         = r_heat_a;
  assign heat_b         = r_heat_b;
  assign budget_limited = r_budget_limited;
  assign period_start   = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_heater_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_heater_scheduler
// Description : Self-checking bench for heater_scheduler with SLOT_CYCLES=4
//               and MAX_SUM=12. A cycle-position reference model predicts
//               all four outputs every clock; vector tables and directed
//               sequences add per-period totals for the key scenarios.
// Config      : HEATER_SCHED_SOFTSTART_EN selects the soft-start model and
//               the ramp sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_heater_scheduler;

  localparam int c_SC     = 4;
  localparam int c_MAXSUM = 12;
  localparam int c_PERIOD = 10 * c_SC;

  logic       clk = 1'b0;
  logic       async_reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] level_a = 4'd0;
  logic [3:0] level_b = 4'd0;
  logic       heat_a;
  logic       heat_b;
  logic       budget_limited;
  logic       period_start;

  heater_scheduler #(
    .SLOT_CYCLES (c_SC),
    .MAX_SUM     (c_MAXSUM)
  ) dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .enable         (enable),
    .level_a        (level_a),
    .level_b        (level_b),
    .heat_a         (heat_a),
    .heat_b         (heat_b),
    .budget_limited (budget_limited),
    .period_start   (period_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the period as a plain cycle count.
  int         m_t, m_pref, m_ga, m_gb, m_lim;
  logic [3:0] m_exp;

  task automatic model_reset();
    m_t = 0; m_pref = 0; m_ga = 0; m_gb = 0; m_lim = 0; m_exp = 4'd0;
  endtask

  task automatic model_edge();
    int a, b, ta, tb, slot;
    if (!async_reset) begin
      model_reset();
      return;
    end
    if (!enable) begin
      m_t = 0; m_ga = 0; m_gb = 0; m_lim = 0; m_exp = 4'd0;
      return;
    end
    if (m_t == 0) begin
      a = (int'(level_a) > 9) ? 9 : int'(level_a);
      b = (int'(level_b) > 9) ? 9 : int'(level_b);
      ta = a; tb = b;
      m_lim = (a + b > c_MAXSUM) ? 1 : 0;
      if (m_lim != 0) begin
        if (m_pref == 0) tb = c_MAXSUM - a;
        else             ta = c_MAXSUM - b;
      end
`ifdef HEATER_SCHED_SOFTSTART_EN
      m_ga = (ta > m_ga + 1) ? m_ga + 1 : ta;
      m_gb = (tb > m_gb + 1) ? m_gb + 1 : tb;
`else
      m_ga = ta;
      m_gb = tb;
`endif
    end
    slot = m_t / c_SC;
    m_exp = {slot < m_ga, slot >= 10 - m_gb, m_lim != 0, m_t == 0};
    if (m_t == c_PERIOD - 1) begin
      if (m_lim != 0) m_pref = 1 - m_pref;
      m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  int cnt_a, cnt_b, cnt_bl, cnt_ps;

  task automatic clear_counts();
    cnt_a = 0; cnt_b = 0; cnt_bl = 0; cnt_ps = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("outputs{ha,hb,bl,ps}", int'({heat_a, heat_b, budget_limited, period_start}), int'(m_exp));
    if (heat_a)         cnt_a++;
    if (heat_b)         cnt_b++;
    if (budget_limited) cnt_bl++;
    if (period_start)   cnt_ps++;
  endtask

  task automatic run_period();
    clear_counts();
    repeat (c_PERIOD) tick();
  endtask

  // Called just after a tick; reset is asserted and released between edges.
  task automatic pulse_reset();
    async_reset = 1'b0;
    #2;
    model_reset();
    check("async_reset_outputs", int'({heat_a, heat_b, budget_limited, period_start}), 0);
    #1;
    async_reset = 1'b1;
  endtask

  typedef struct {
    int la;
    int lb;
    int ga;
    int gb;
    int lim;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3, 2, 3, 2, 0};
    vecs[1]  = '{9, 9, 9, 3, 1};
    vecs[2]  = '{0, 0, 0, 0, 0};
    vecs[3]  = '{9, 0, 9, 0, 0};
    vecs[4]  = '{0, 9, 0, 9, 0};
    vecs[5]  = '{6, 6, 6, 6, 0};
    vecs[6]  = '{7, 6, 7, 5, 1};
    vecs[7]  = '{15, 1, 9, 1, 0};
    vecs[8]  = '{12, 14, 9, 3, 1};
    vecs[9]  = '{5, 8, 5, 7, 1};
    vecs[10] = '{4, 8, 4, 8, 0};

    model_reset();
    clear_counts();

    // Reset state
    repeat (3) tick();
    check("reset_state", int'({heat_a, heat_b, budget_limited, period_start}), 0);
    async_reset = 1'b1;
    repeat (2) tick();
    check("disabled_idle", int'({heat_a, heat_b, budget_limited, period_start}), 0);

`ifndef HEATER_SCHED_SOFTSTART_EN
    // Single-period vectors from a fresh reset (preference A)
    for (int i = 0; i < 11; i++) begin
      level_a = 4'(vecs[i].la);
      level_b = 4'(vecs[i].lb);
      enable  = 1'b1;
      pulse_reset();
      run_period();
      check($sformatf("vec%0d_heat_a_cycles", i), cnt_a, vecs[i].ga * c_SC);
      check($sformatf("vec%0d_heat_b_cycles", i), cnt_b, vecs[i].gb * c_SC);
      check($sformatf("vec%0d_limited_cycles", i), cnt_bl, vecs[i].lim * c_PERIOD);
      check($sformatf("vec%0d_period_starts", i), cnt_ps, 1);
      tick();
      check($sformatf("vec%0d_period_len", i), int'(period_start), 1);
    end

    // Two clipped periods: preference alternates
    level_a = 4'd9; level_b = 4'd9;
    pulse_reset();
    run_period();
    check("alt_p1_heat_a", cnt_a, 36);
    check("alt_p1_heat_b", cnt_b, 12);
    run_period();
    check("alt_p2_heat_a", cnt_a, 12);
    check("alt_p2_heat_b", cnt_b, 36);
    check("alt_p2_limited", cnt_bl, c_PERIOD);

    // Mid-period level change takes effect only next period
    level_a = 4'd2; level_b = 4'd0;
    pulse_reset();
    clear_counts();
    repeat (17) tick();
    level_a = 4'd7;
    repeat (c_PERIOD - 17) tick();
    check("midchange_cur_period", cnt_a, 8);
    run_period();
    check("midchange_next_period", cnt_a, 28);

    // Reset mid-slot restores preference A
    level_a = 4'd9; level_b = 4'd9;
    pulse_reset();
    repeat (c_PERIOD + 6) tick();
    pulse_reset();
    run_period();
    check("reset_pref_heat_a", cnt_a, 36);
    check("reset_pref_heat_b", cnt_b, 12);
`else
    // Soft start: ramp up one level per period, drop at once
    level_a = 4'd0; level_b = 4'd0;
    enable  = 1'b1;
    pulse_reset();
    run_period();
    check("ramp_base", cnt_a, 0);
    level_a = 4'd9;
    for (int k = 1; k <= 9; k++) begin
      run_period();
      check($sformatf("ramp_step%0d", k), cnt_a, k * c_SC);
    end
    level_a = 4'd0;
    run_period();
    check("ramp_drop", cnt_a, 0);
`endif

    // Enable dropped in slot 5, then restarted
    level_a = 4'd9; level_b = 4'd9;
    enable  = 1'b1;
    pulse_reset();
    repeat (22) tick();
    enable = 1'b0;
    tick();
    check("abort_heat", int'({heat_a, heat_b}), 0);
    repeat (3) tick();
    enable = 1'b1;
    tick();
    check("reenable_period_start", int'(period_start), 1);
    check("reenable_heat_a_slot0", int'(heat_a), 1);
    clear_counts();
    repeat (c_PERIOD - 1) tick();
    check("reenable_no_early_start", cnt_ps, 0);
    tick();
    check("reenable_next_start", int'(period_start), 1);

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        level_a = 4'($urandom_range(0, 15));
        level_b = 4'($urandom_range(0, 15));
      end
      if (enable ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 4) == 0)) begin
        enable = ~enable;
      end
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset();
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
